// File: rtl/instr_fetch_buffer_if.sv
// Fetch-side bus bundle: instruction-memory req/gnt/rvalid channel plus the
// valid/ready channel toward decode.
interface instr_fetch_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              id_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid, id_instr, id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid, id_instr, id_pc,
    output id_ready
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: issues in-order imem requests for the current PC and
// buffers {pc, instr} pairs for decode; redirects flush and discard in-flight data.
module instr_fetch_buffer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic                  active,
  input  logic                  flush,
  output logic                  fetch_stall,
  output logic                  proto_err,
  instr_fetch_buffer_if.master  bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  // Discards can pile up over repeated redirects, so give them headroom.
  localparam int unsigned DISC_W = CNT_W + 4;

  logic                 run_q, run_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     pend_q, pend_d;
  logic [DISC_W-1:0]    disc_q, disc_d;
  logic                 proto_err_q, proto_err_d;
  logic [DEPTH-1:0]     filled_q, filled_d;
  logic [ADDR_W-1:0]    pc_mem_q [DEPTH];
  logic [ADDR_W-1:0]    pc_mem_d [DEPTH];
  logic [DATA_W-1:0]    instr_mem_q [DEPTH];
  logic [DATA_W-1:0]    instr_mem_d [DEPTH];

  logic req_c, grant_c, head_valid_c, pop_c, drop_c, fill_c, spur_c;

  // Handshake decode; run_q keeps requests off for the first cycle out of reset.
  always_comb begin
    req_c        = run_q & active & ~flush & (count_q < CNT_W'(DEPTH));
    grant_c      = req_c & bus.imem_gnt;
    head_valid_c = filled_q[rd_ptr_q] & ~flush;
    pop_c        = head_valid_c & bus.id_ready;
    drop_c       = bus.imem_rvalid & (disc_q != '0);
    fill_c       = bus.imem_rvalid & (disc_q == '0) & (pend_q != '0);
    spur_c       = bus.imem_rvalid & (disc_q == '0) & (pend_q == '0);
  end

  // Next-state logic for pointers, counters and entry storage.
  always_comb begin
    run_d       = 1'b1;
    wr_ptr_d    = wr_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    disc_d      = disc_q - DISC_W'(drop_c);
    proto_err_d = proto_err_q | spur_c;
    filled_d    = filled_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (flush) begin
      // Every allocated-but-unfilled entry becomes a response to throw away.
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pend_d     = '0;
      filled_d   = '0;
      disc_d     = disc_q + DISC_W'(pend_q) - DISC_W'(drop_c) - DISC_W'(fill_c);
    end else begin
      if (grant_c) begin
        pc_mem_d[wr_ptr_q] = pc_in;
        filled_d[wr_ptr_q] = 1'b0;
        wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      if (fill_c) begin
        instr_mem_d[fill_ptr_q] = bus.imem_rdata;
        filled_d[fill_ptr_q]    = 1'b1;
        fill_ptr_d              = fill_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(grant_c) - CNT_W'(pop_c);
      pend_d  = pend_q + CNT_W'(grant_c) - CNT_W'(fill_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      wr_ptr_q    <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      disc_q      <= '0;
      proto_err_q <= 1'b0;
      filled_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      run_q       <= run_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      disc_q      <= disc_d;
      proto_err_q <= proto_err_d;
      filled_q    <= filled_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  assign bus.imem_req  = req_c;
  assign bus.imem_addr = pc_in;
  assign fetch_stall   = ~grant_c;
  assign bus.id_valid  = head_valid_c;
  assign bus.id_instr  = instr_mem_q[rd_ptr_q];
  assign bus.id_pc     = pc_mem_q[rd_ptr_q];
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer (DEPTH=2): reset, streaming, backpressure,
// flush with in-flight responses, back-to-back flushes and spurious rvalid.
module tb_instr_fetch_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        active;
  logic        flush;
  logic        fetch_stall;
  logic        proto_err;

  int n_cmp;
  int n_err;
  logic exp_perr;

  instr_fetch_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .active      (active),
    .flush       (flush),
    .fetch_stall (fetch_stall),
    .proto_err   (proto_err),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] p);
    return 32'hA000_0000 | p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs mid-cycle, then settle before checking.
  task automatic drv(input logic a, input logic [31:0] pc, input logic g, input logic rv,
                     input logic [31:0] rd, input logic rdy, input logic fl);
    @(negedge clk);
    active          = a;
    pc_in           = pc;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.id_ready    = rdy;
    flush           = fl;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic stall,
                            input logic idv, input logic [31:0] pc);
    chk({tag, "/req"}, 32'(bus.imem_req), 32'(req));
    if (req) chk({tag, "/addr"}, bus.imem_addr, pc_in);
    chk({tag, "/stall"}, 32'(fetch_stall), 32'(stall));
    chk({tag, "/idv"}, 32'(bus.id_valid), 32'(idv));
    if (idv) begin
      chk({tag, "/idpc"}, bus.id_pc, pc);
      chk({tag, "/instr"}, bus.id_instr, ins(pc));
    end
    chk({tag, "/perr"}, 32'(proto_err), 32'(exp_perr));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_perr = 1'b0;
    rst = 1'b0;
    active = 1'b1;
    pc_in = 32'h0;
    flush = 1'b0;
    bus.imem_gnt = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.id_ready = 1'b1;

    // Reset held with live stimulus
    #2;
    chk("rst/req", 32'(bus.imem_req), 32'd0);
    chk("rst/stall", 32'(fetch_stall), 32'd1);
    chk("rst/idv", 32'(bus.id_valid), 32'd0);
    chk("rst/perr", 32'(proto_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst2/perr", 32'(proto_err), 32'd0);
    chk("rst2/idpc", bus.id_pc, 32'd0);
    chk("rst2/instr", bus.id_instr, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    active = 1'b0;
    bus.imem_rvalid = 1'b0;
    #1;
    chk("rel/req", 32'(bus.imem_req), 32'd0);

    // Streaming, gnt always, 1-cycle response latency
    drv(1'b1, 32'h0,  1'b1, 1'b0, 32'h0,      1'b1, 1'b0); expect_out("s0", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h4,  1'b1, 1'b1, ins(32'h0), 1'b1, 1'b0); expect_out("s1", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h8,  1'b1, 1'b1, ins(32'h4), 1'b1, 1'b0); expect_out("s2", 1'b0, 1'b1, 1'b1, 32'h0);
    drv(1'b1, 32'h8,  1'b1, 1'b0, 32'h0,      1'b1, 1'b0); expect_out("s3", 1'b1, 1'b0, 1'b1, 32'h4);
    drv(1'b1, 32'hC,  1'b1, 1'b1, ins(32'h8), 1'b1, 1'b0); expect_out("s4", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h10, 1'b1, 1'b1, ins(32'hC), 1'b1, 1'b0); expect_out("s5", 1'b0, 1'b1, 1'b1, 32'h8);
    drv(1'b1, 32'h10, 1'b1, 1'b0, 32'h0,      1'b1, 1'b0); expect_out("s6", 1'b1, 1'b0, 1'b1, 32'hC);
    drv(1'b0, 32'h14, 1'b1, 1'b1, ins(32'h10),1'b1, 1'b0); expect_out("s7", 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 32'h14, 1'b1, 1'b0, 32'h0,      1'b1, 1'b0); expect_out("s8", 1'b0, 1'b1, 1'b1, 32'h10);
    drv(1'b0, 32'h14, 1'b1, 1'b0, 32'h0,      1'b1, 1'b0); expect_out("s9", 1'b0, 1'b1, 1'b0, 32'h0);

    // Backpressure until full, then release one at a time
    drv(1'b1, 32'h40, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0); expect_out("b0", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h44, 1'b1, 1'b1, ins(32'h40), 1'b0, 1'b0); expect_out("b1", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h48, 1'b1, 1'b1, ins(32'h44), 1'b0, 1'b0); expect_out("b2", 1'b0, 1'b1, 1'b1, 32'h40);
    drv(1'b1, 32'h48, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0); expect_out("b3", 1'b0, 1'b1, 1'b1, 32'h40);
    drv(1'b1, 32'h48, 1'b1, 1'b0, 32'h0,       1'b1, 1'b0); expect_out("b4", 1'b0, 1'b1, 1'b1, 32'h40);
    drv(1'b1, 32'h48, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0); expect_out("b5", 1'b1, 1'b0, 1'b1, 32'h44);
    drv(1'b0, 32'h4C, 1'b1, 1'b1, ins(32'h48), 1'b1, 1'b0); expect_out("b6", 1'b0, 1'b1, 1'b1, 32'h44);
    drv(1'b0, 32'h4C, 1'b1, 1'b0, 32'h0,       1'b1, 1'b0); expect_out("b7", 1'b0, 1'b1, 1'b1, 32'h48);
    drv(1'b0, 32'h4C, 1'b1, 1'b0, 32'h0,       1'b1, 1'b0); expect_out("b8", 1'b0, 1'b1, 1'b0, 32'h0);

    // Flush with two requests in flight
    drv(1'b1, 32'h10,  1'b1, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("f0", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h14,  1'b1, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("f1", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h100, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1); expect_out("f2", 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 32'h100, 1'b1, 1'b1, ins(32'h10),  1'b1, 1'b0); expect_out("f3", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h104, 1'b0, 1'b1, ins(32'h14),  1'b1, 1'b0); expect_out("f4", 1'b1, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 32'h104, 1'b0, 1'b1, ins(32'h100), 1'b1, 1'b0); expect_out("f5", 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 32'h104, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("f6", 1'b0, 1'b1, 1'b1, 32'h100);
    drv(1'b0, 32'h104, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("f7", 1'b0, 1'b1, 1'b0, 32'h0);

    // Flush coinciding with the only outstanding response
    drv(1'b1, 32'h200, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("g0", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h300, 1'b1, 1'b1, ins(32'h200), 1'b1, 1'b1); expect_out("g1", 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 32'h300, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("g2", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 32'h304, 1'b1, 1'b1, ins(32'h300), 1'b1, 1'b0); expect_out("g3", 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 32'h304, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("g4", 1'b0, 1'b1, 1'b1, 32'h300);
    drv(1'b0, 32'h304, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("g5", 1'b0, 1'b1, 1'b0, 32'h0);

    // Back-to-back flushes keep the pending discard
    drv(1'b1, 32'h400, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("h0", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h404, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1); expect_out("h1", 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 32'h500, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1); expect_out("h2", 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 32'h500, 1'b1, 1'b1, ins(32'h400), 1'b1, 1'b0); expect_out("h3", 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 32'h504, 1'b1, 1'b1, ins(32'h500), 1'b1, 1'b0); expect_out("h4", 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 32'h504, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0); expect_out("h5", 1'b0, 1'b1, 1'b1, 32'h500);

    // Spurious response with nothing outstanding
    drv(1'b0, 32'h504, 1'b0, 1'b1, 32'h0000_0BAD, 1'b1, 1'b0); expect_out("x0", 1'b0, 1'b1, 1'b0, 32'h0);
    exp_perr = 1'b1;
    drv(1'b0, 32'h504, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); expect_out("x1", 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b0, 32'h504, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); expect_out("x2", 1'b0, 1'b1, 1'b0, 32'h0);

    // Reset clears the sticky error; a post-reset rvalid sets it again
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("r2/perr", 32'(proto_err), 32'd0);
    chk("r2/stall", 32'(fetch_stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.imem_rvalid = 1'b1;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    #1;
    chk("r3/perr", 32'(proto_err), 32'd1);
    chk("r3/idv", 32'(bus.id_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
